// File: rtl/f1_light_seq_if.sv
// Bus between the F1 start-light sequencer and its tick/LFSR/light neighbours.
// Optional abort line present only when F1_LIGHT_SEQ_ABORT_EN is defined.
interface f1_light_seq_if #(
    parameter int N_LIGHTS = 8,
    parameter int DELAY_W  = 7
);
    logic                en;
    logic                trigger;
    logic [DELAY_W-1:0]  delay_val;
    logic [N_LIGHTS-1:0] data_out;
    logic                busy;
    logic                done;
`ifdef F1_LIGHT_SEQ_ABORT_EN
    logic                abort;
`endif

    modport master (
`ifdef F1_LIGHT_SEQ_ABORT_EN
        output abort,
`endif
        output en, trigger, delay_val,
        input  data_out, busy, done
    );

    modport slave (
`ifdef F1_LIGHT_SEQ_ABORT_EN
        input  abort,
`endif
        input  en, trigger, delay_val,
        output data_out, busy, done
    );
endinterface

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills the light register one tick at a time, holds for an
// LFSR-supplied delay, then clears and pulses done. Optional abort: F1_LIGHT_SEQ_ABORT_EN.
module f1_light_seq #(
    parameter int N_LIGHTS = 8,
    parameter int DELAY_W  = 7
) (
    input  logic            clk,
    input  logic            rst,
    f1_light_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [N_LIGHTS-1:0] LIGHTS_OFF = {N_LIGHTS{1'b0}};
    localparam logic [N_LIGHTS-1:0] LIGHTS_ON  = {N_LIGHTS{1'b1}};
    localparam logic [DELAY_W-1:0]  CNT_ZERO   = {DELAY_W{1'b0}};
    localparam logic [DELAY_W-1:0]  CNT_ONE    = DELAY_W'(1'b1);

    state_t              state_r, state_s;
    logic [N_LIGHTS-1:0] data_r, data_s;
    logic [N_LIGHTS-1:0] shifted_s;
    logic [DELAY_W-1:0]  cnt_r, cnt_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                abort_s;

`ifdef F1_LIGHT_SEQ_ABORT_EN
    assign abort_s = bus.abort && ((state_r == ST_FILL) || (state_r == ST_HOLD));
`else
    assign abort_s = 1'b0;
`endif

    assign shifted_s = {data_r[N_LIGHTS-2:0], 1'b1};

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            data_r  <= LIGHTS_OFF;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        if (abort_s) begin
            state_s = ST_IDLE;
            data_s  = LIGHTS_OFF;
            cnt_s   = CNT_ZERO;
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_s = LIGHTS_OFF;
                    cnt_s  = CNT_ZERO;
                    // en on the entry edge is deliberately not used as a shift
                    if (bus.trigger) begin
                        state_s = ST_FILL;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                    end
                end
                ST_FILL: begin
                    busy_s = 1'b1;
                    if (bus.en) begin
                        data_s = shifted_s;
                        if (&shifted_s) begin
                            state_s = ST_HOLD;
                            // a zero delay is promoted to one so the countdown never wraps
                            cnt_s   = (bus.delay_val == CNT_ZERO) ? CNT_ONE : bus.delay_val;
                        end else begin
                            state_s = ST_FILL;
                        end
                    end else begin
                        state_s = ST_FILL;
                    end
                end
                ST_HOLD: begin
                    data_s = LIGHTS_ON;
                    busy_s = 1'b1;
                    if (bus.en) begin
                        if (cnt_r <= CNT_ONE) begin
                            state_s = ST_IDLE;
                            data_s  = LIGHTS_OFF;
                            cnt_s   = CNT_ZERO;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            cnt_s   = cnt_r - CNT_ONE;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    data_s  = LIGHTS_OFF;
                    cnt_s   = CNT_ZERO;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq: reset, normal fill/hold, zero delay, delay latching,
// trigger while busy, mid-run reset and (with F1_LIGHT_SEQ_ABORT_EN) abort.
module tb_f1_light_seq;
    localparam int N  = 8;
    localparam int DW = 7;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    f1_light_seq_if #(.N_LIGHTS(N), .DELAY_W(DW)) bus ();

    f1_light_seq #(.N_LIGHTS(N), .DELAY_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] d, input logic b, input logic dn);
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(d));
        chk({tag, ".busy"},     32'(bus.busy),     32'(b));
        chk({tag, ".done"},     32'(bus.done),     32'(dn));
    endtask

    task automatic step(input logic e, input logic t);
        bus.en      = e;
        bus.trigger = t;
        @(posedge clk);
        #1;
    endtask

    task automatic en_pulse();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b1;
        bus.trigger   = 1'b1;
        bus.delay_val = 7'd3;
`ifdef F1_LIGHT_SEQ_ABORT_EN
        bus.abort     = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0);
        check_out("reset", 8'h00, 1'b0, 1'b0);

        // normal run, en every 4th cycle, delay 3
        step(1'b0, 1'b1);
        check_out("trig_entry", 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_out("fill_no_en", 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= N; i++) begin
            en_pulse();
            check_out($sformatf("fill%0d", i), 8'((32'd1 << i) - 32'd1), 1'b1, 1'b0);
        end
        en_pulse();
        check_out("hold1", 8'hFF, 1'b1, 1'b0);
        en_pulse();
        check_out("hold2", 8'hFF, 1'b1, 1'b0);
        en_pulse();
        check_out("hold_end", 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_out("done_drop", 8'h00, 1'b0, 1'b0);

        // delay 5 latched then changed; trigger held during fill
        bus.delay_val = 7'd5;
        step(1'b0, 1'b1);
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 1'b1);
            check_out($sformatf("fill_trig%0d", i), 8'((32'd1 << i) - 32'd1), 1'b1, 1'b0);
        end
        bus.delay_val = 7'd1;
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0);
            check_out($sformatf("latch_hold%0d", k), 8'hFF, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1);
        check_out("latch_end", 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_out("retrigger_entry", 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_out("retrigger_first", 8'h01, 1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_out("mid_fill", 8'h0F, 1'b1, 1'b0);

        // reset mid-fill
        rst = 1'b1;
        step(1'b1, 1'b1);
        check_out("mid_reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check_out("post_reset", 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check_out("restart", 8'h01, 1'b1, 1'b0);

        // zero delay promoted to one
        bus.delay_val = 7'd0;
        for (int i = 2; i <= N; i++) step(1'b1, 1'b0);
        check_out("zero_full", 8'hFF, 1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_out("zero_end", 8'h00, 1'b0, 1'b1);

`ifdef F1_LIGHT_SEQ_ABORT_EN
        bus.delay_val = 7'd4;
        step(1'b0, 1'b1);
        for (int i = 1; i <= N; i++) step(1'b1, 1'b0);
        check_out("abort_full", 8'hFF, 1'b1, 1'b0);
        bus.abort = 1'b1;
        step(1'b1, 1'b1);
        check_out("abort_hold", 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_out("abort_idle", 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_out("abort_idle_trig", 8'h00, 1'b1, 1'b0);
        bus.abort = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
